step_dir_decoder: RTL and testbench
===================================

# step_dir_decoder

Receive-side counterpart of the step/dir generator: it samples an external step/dir pulse stream, such as a step_gen output looped back or a manual pulse generator. It does four things:
- filters short glitches on step,
- tracks a signed 32-bit position,
- measures the period between accepted steps,
- flags direction-timing violations.

One instance sits per axis beside the step generators in the CNC Avalon peripheral. Its outputs are exposed as read-only registers for step-loss checking and for closing the loop.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on istep/idir (≥2)
- FILT_W, 8: width of min_high

Ports:
- clk  in  1  system clock; the only clock
- reset_n  in  1  reset, synchronous, active-low
- istep  in  1  asynchronous external step input, active-high
- idir  in  1  asynchronous external direction input; 1 = count up, 0 = count down
- en  in  1  decoder enable
- clr  in  1  one-cycle clear of position, period and flags
- min_high  in  FILT_W  minimum qualified high time in clk cycles; 0 behaves as 1
- position  out  32  signed step count
- period  out  32  clk cycles between the last two accepted steps
- period_valid  out  1  period holds a real measurement
- step_pulse  out  1  one-cycle strobe per accepted step
- dir_out  out  1  synchronized idir
- dir_err  out  1  sticky flag: direction changed while step was asserted

## Operation
- **Synchronization:** istep and idir each pass through SYNC_STAGES flops, giving step_s and dir_s. dir_out = dir_s.
- **Filter FSM (state → condition → action):**
  - LOW: step_s=1 → go to QUAL, set flt_cnt=1.
  - QUAL: step_s=0 → go to LOW (glitch rejected). Otherwise, if flt_cnt ≥ max(min_high,1) → go to HIGH and accept a step; else flt_cnt+1.
  - HIGH: step_s=0 → go to LOW.
  - With min_high ≤ 1, LOW goes straight to HIGH and accepts on the first high sample.
- **Accepted step:** on the same edge that raises step_pulse:
  - position ±1, direction taken from dir_s at that edge.
  - Arithmetic is modulo 2^32: 0x7FFFFFFF+1 → 0x80000000; 0x00000000−1 → 0xFFFFFFFF.
- **Period measurement:**
  - per_cnt increments every enabled cycle and saturates at 0xFFFFFFFF.
  - On an accepted step: period ← per_cnt and per_cnt ← 1.
  - period_valid rises on the second accepted step after reset, clr or en rising.
  - period_valid clears when per_cnt saturates (stall); period holds its last value.
- **dir_err:** set when dir_s changes while the FSM is in QUAL or HIGH. Stays set until clr or reset.
- **en=0:**
  - FSM is forced to LOW and no steps are accepted.
  - position, period and dir_err hold.
  - per_cnt ← 0 and period_valid ← 0.
- **clr:** position, period, per_cnt ← 0; period_valid, dir_err ← 0; FSM is unaffected.
  - clr coincident with an accepted step: clr wins, step_pulse is suppressed and position = 0.
- **Changing min_high mid-pulse:** takes effect at the next comparison.

## Timing
- **Reset values:** position=0, period=0, period_valid=0, step_pulse=0, dir_err=0, dir_out=0; synchronizers 0; FSM=LOW.
- **Step latency:** step_pulse is high exactly SYNC_STAGES + max(min_high,1) clk edges after the first edge that samples istep=1, and lasts one cycle.
- **Update timing:** position and period update on that same edge.
- **Direction setup:** idir must be stable SYNC_STAGES cycles before istep rises to be used.
- **Minimum step period:** the minimum accepted step period is max(min_high,1)+1 cycles high/low combined. Faster input merges pulses; this is not detected.
- **Reset mid-pulse:** the FSM returns to LOW and a still-high istep is counted as a new step once it is requalified.

## Structure
- **Shared package cnc_pkg:**
  - State enum {LOW, QUAL, HIGH}.
  - POS_W=32.
  - PER_MAX=32'hFFFFFFFF.
- **Sub-module:** cnc_sync, a SYNC_STAGES-deep flop chain with synchronous active-low reset, instantiated twice.
- **Target size:** ~150–200 lines of RTL.

## Test plan
- **Reset / basic counting:** reset, en=1, min_high=1, idir=1, five 4-cycle-high/4-cycle-low pulses → five step_pulses, each 3 edges after the istep rise; position=5; period=8; period_valid=1 after the 2nd step.
- **Glitch filter:** min_high=4; pulses of 3 cycles high → no step_pulse, position unchanged; 4-cycle pulse → one step, latency 6 edges.
- **Wrap:** clr, idir=0, one step → position=0xFFFFFFFF; preload via 0x7FFFFFFF up-steps in the model-based bench, next up-step → 0x80000000.
- **Direction error:** toggle idir while istep is held high → dir_err=1 and stays set; clr → dir_err=0.
- **clr / enable edges:**
  - clr on the same cycle as an accepted step → position=0, no step_pulse.
  - en=0 during a pulse train → no counting, period_valid=0.
  - Re-enable → period_valid only after 2 steps.
- **Stall:** no steps for 2^32 cycles (force per_cnt near PER_MAX) → period_valid=0 with period held; next two steps restore period_valid.

Source files
------------

// File: rtl/cnc_pkg.sv
// Shared types and constants for the CNC step/dir blocks.
package cnc_pkg;

  localparam int unsigned POS_W   = 32;
  localparam logic [31:0] PER_MAX = 32'hFFFF_FFFF;

  // Step glitch-filter states.
  typedef enum logic [1:0] {
    StLow,
    StQual,
    StHigh
  } flt_state_e;

endpackage

// File: rtl/cnc_sync.sv
// Multi-flop synchronizer for a single asynchronous input.
module cnc_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q, sync_d;

  // Shift the raw input in at bit 0; the oldest sample is the output.
  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  // Synchronizer chain with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: glitch filter, signed position, step period and direction-timing flag.
module step_dir_decoder
  import cnc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              istep,
  input  logic              idir,
  input  logic              en,
  input  logic              clr,
  input  logic [FILT_W-1:0] min_high,
  output logic [POS_W-1:0]  position,
  output logic [31:0]       period,
  output logic              period_valid,
  output logic              step_pulse,
  output logic              dir_out,
  output logic              dir_err
);

  localparam logic [FILT_W:0] CntOne = {{FILT_W{1'b0}}, 1'b1};

  logic step_s, dir_s;

  flt_state_e        state_q, state_d;
  logic [FILT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic [FILT_W:0]   mh_eff, cnt_inc;
  logic              accept;

  logic [POS_W-1:0]  position_q, position_d;
  logic [31:0]       period_q, period_d;
  logic [31:0]       per_cnt_q, per_cnt_d;
  logic              period_valid_q, period_valid_d;
  logic              have_first_q, have_first_d;
  logic              step_pulse_q, step_pulse_d;
  logic              dir_err_q, dir_err_d;
  logic              dir_prev_q;

  cnc_sync #(
    .Stages (SYNC_STAGES)
  ) u_sync_step (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (istep),
    .q_o    (step_s)
  );

  cnc_sync #(
    .Stages (SYNC_STAGES)
  ) u_sync_dir (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (idir),
    .q_o    (dir_s)
  );

  // Filter FSM: qualify step high time; the current high sample counts toward min_high.
  always_comb begin
    state_d   = state_q;
    flt_cnt_d = flt_cnt_q;
    accept    = 1'b0;
    mh_eff    = (min_high == '0) ? CntOne : {1'b0, min_high};
    cnt_inc   = {1'b0, flt_cnt_q} + CntOne;
    if (!en) begin
      state_d = StLow;
    end else begin
      case (state_q)
        StLow: begin
          if (step_s) begin
            if (mh_eff == CntOne) begin
              state_d = StHigh;
              accept  = 1'b1;
            end else begin
              state_d   = StQual;
              flt_cnt_d = CntOne[FILT_W-1:0];
            end
          end
        end
        StQual: begin
          if (!step_s) begin
            state_d = StLow;
          end else if (cnt_inc >= mh_eff) begin
            state_d = StHigh;
            accept  = 1'b1;
          end else begin
            flt_cnt_d = cnt_inc[FILT_W-1:0];
          end
        end
        StHigh: begin
          if (!step_s) begin
            state_d = StLow;
          end
        end
        default: state_d = StLow;
      endcase
    end
  end

  // Position, period measurement and sticky direction error; clr overrides everything.
  always_comb begin
    position_d     = position_q;
    period_d       = period_q;
    per_cnt_d      = per_cnt_q;
    period_valid_d = period_valid_q;
    have_first_d   = have_first_q;
    dir_err_d      = dir_err_q;
    step_pulse_d   = 1'b0;
    if (clr) begin
      position_d     = '0;
      period_d       = '0;
      per_cnt_d      = '0;
      period_valid_d = 1'b0;
      have_first_d   = 1'b0;
      dir_err_d      = 1'b0;
    end else if (!en) begin
      per_cnt_d      = '0;
      period_valid_d = 1'b0;
      have_first_d   = 1'b0;
    end else begin
      per_cnt_d = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + 32'd1;
      // A stalled counter invalidates the measurement; two fresh steps are needed.
      if (per_cnt_q == PER_MAX) begin
        period_valid_d = 1'b0;
        have_first_d   = 1'b0;
      end
      if (accept) begin
        step_pulse_d   = 1'b1;
        position_d     = dir_s ? position_q + 32'd1 : position_q - 32'd1;
        period_d       = per_cnt_q;
        per_cnt_d      = 32'd1;
        period_valid_d = have_first_q && (per_cnt_q != PER_MAX);
        have_first_d   = 1'b1;
      end
      if ((dir_s != dir_prev_q) && (state_q != StLow)) begin
        dir_err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= StLow;
      flt_cnt_q      <= '0;
      position_q     <= '0;
      period_q       <= '0;
      per_cnt_q      <= '0;
      period_valid_q <= 1'b0;
      have_first_q   <= 1'b0;
      step_pulse_q   <= 1'b0;
      dir_err_q      <= 1'b0;
      dir_prev_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      flt_cnt_q      <= flt_cnt_d;
      position_q     <= position_d;
      period_q       <= period_d;
      per_cnt_q      <= per_cnt_d;
      period_valid_q <= period_valid_d;
      have_first_q   <= have_first_d;
      step_pulse_q   <= step_pulse_d;
      dir_err_q      <= dir_err_d;
      dir_prev_q     <= dir_s;
    end
  end

  assign position     = position_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign step_pulse   = step_pulse_q;
  assign dir_out      = dir_s;
  assign dir_err      = dir_err_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed self-checking bench for step_dir_decoder.
module tb_step_dir_decoder;

  logic        clk = 1'b0;
  logic        reset_n, istep, idir, en, clr;
  logic [7:0]  min_high;
  logic [31:0] position, period;
  logic        period_valid, step_pulse, dir_out, dir_err;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int base_cnt;

  step_dir_decoder #(
    .SYNC_STAGES (2),
    .FILT_W      (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .istep        (istep),
    .idir         (idir),
    .en           (en),
    .clr          (clr),
    .min_high     (min_high),
    .position     (position),
    .period       (period),
    .period_valid (period_valid),
    .step_pulse   (step_pulse),
    .dir_out      (dir_out),
    .dir_err      (dir_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step_pulse === 1'b1) pulse_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // 4 cycles high, 4 low; with min_high=1 the step is accepted on the 3rd edge.
  task automatic pulse_step();
    istep = 1'b1;
    repeat (4) tick();
    istep = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset_n  = 1'b0;
    istep    = 1'b0;
    idir     = 1'b0;
    en       = 1'b0;
    clr      = 1'b0;
    min_high = 8'd1;
    repeat (3) tick();
    check("rst_position", position, 32'd0);
    check("rst_period", period, 32'd0);
    check_b("rst_pvalid", period_valid, 1'b0);
    check_b("rst_step_pulse", step_pulse, 1'b0);
    check_b("rst_dir_err", dir_err, 1'b0);
    check_b("rst_dir_out", dir_out, 1'b0);
    reset_n = 1'b1;

    // Basic counting, min_high=1.
    en   = 1'b1;
    idir = 1'b1;
    repeat (3) tick();
    check_b("dir_out_up", dir_out, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      istep = 1'b1;
      tick();
      tick();
      check_b("lat_early", step_pulse, 1'b0);
      tick();
      check_b("lat_pulse", step_pulse, 1'b1);
      check("count_pos", position, 32'(k));
      check_b("count_pvalid", period_valid, k >= 2);
      if (k >= 2) check("count_period", period, 32'd8);
      tick();
      check_b("pulse_width", step_pulse, 1'b0);
      istep = 1'b0;
      repeat (4) tick();
    end
    check("count_final", position, 32'd5);
    check_b("count_no_dir_err", dir_err, 1'b0);

    // Glitch filter, min_high=4.
    min_high = 8'd4;
    base_cnt = pulse_cnt;
    repeat (2) begin
      istep = 1'b1;
      repeat (3) tick();
      istep = 1'b0;
      repeat (6) tick();
    end
    check("glitch_no_pulse", 32'(pulse_cnt), 32'(base_cnt));
    check("glitch_pos", position, 32'd5);
    istep = 1'b1;
    repeat (4) tick();
    istep = 1'b0;
    tick();
    check_b("filt_lat_early", step_pulse, 1'b0);
    tick();
    check_b("filt_lat_pulse", step_pulse, 1'b1);
    check("filt_pos", position, 32'd6);
    repeat (8) tick();

    // Wrap both ways.
    min_high = 8'd1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_pos", position, 32'd0);
    check("clr_period", period, 32'd0);
    check_b("clr_pvalid", period_valid, 1'b0);
    idir = 1'b0;
    repeat (3) tick();
    pulse_step();
    check("wrap_down", position, 32'hFFFF_FFFF);
    force dut.position_q = 32'h7FFF_FFFF;
    tick();
    release dut.position_q;
    tick();
    check("preload", position, 32'h7FFF_FFFF);
    idir = 1'b1;
    repeat (3) tick();
    pulse_step();
    check("wrap_up", position, 32'h8000_0000);

    // Direction change while step is high.
    istep = 1'b1;
    repeat (4) tick();
    idir = 1'b0;
    repeat (4) tick();
    check_b("dir_err_set", dir_err, 1'b1);
    istep = 1'b0;
    idir  = 1'b1;
    repeat (8) tick();
    check_b("dir_err_sticky", dir_err, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_b("dir_err_clr", dir_err, 1'b0);
    repeat (3) tick();

    // clr on the accepting edge wins.
    base_cnt = pulse_cnt;
    istep = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_b("clr_step_no_pulse", step_pulse, 1'b0);
    check("clr_step_pos", position, 32'd0);
    tick();
    istep = 1'b0;
    repeat (4) tick();
    check("clr_step_cnt", 32'(pulse_cnt), 32'(base_cnt));

    // Enable gating and re-enable.
    pulse_step();
    pulse_step();
    check("en_pre_pos", position, 32'd2);
    check_b("en_pre_pvalid", period_valid, 1'b1);
    en = 1'b0;
    tick();
    check_b("en_off_pvalid", period_valid, 1'b0);
    base_cnt = pulse_cnt;
    pulse_step();
    pulse_step();
    check("en_off_pos", position, 32'd2);
    check("en_off_period", period, 32'd8);
    check("en_off_cnt", 32'(pulse_cnt), 32'(base_cnt));
    en = 1'b1;
    tick();
    pulse_step();
    check("reen_pos1", position, 32'd3);
    check_b("reen_pvalid1", period_valid, 1'b0);
    pulse_step();
    check("reen_pos2", position, 32'd4);
    check_b("reen_pvalid2", period_valid, 1'b1);
    check("reen_period", period, 32'd8);

    // Stall: push the period counter to saturation.
    force dut.per_cnt_q = 32'hFFFF_FFF0;
    tick();
    release dut.per_cnt_q;
    repeat (24) tick();
    check_b("stall_pvalid", period_valid, 1'b0);
    check("stall_period_held", period, 32'd8);
    pulse_step();
    check_b("stall_pvalid1", period_valid, 1'b0);
    check("stall_period_sat", period, 32'hFFFF_FFFF);
    pulse_step();
    check_b("stall_pvalid2", period_valid, 1'b1);
    check("stall_period", period, 32'd8);
    check("stall_pos", position, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
